// File: rtl/ttl_pkg.sv
// Shared definitions for the TTL-style latch/selector family.
// Mode is the concatenation {g, clr}; both are active-low.
package ttl_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_DEMUX = 2'b00;
  localparam mode_t MODE_LATCH = 2'b01;
  localparam mode_t MODE_CLR   = 2'b10;
  localparam mode_t MODE_MEM   = 2'b11;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/addr_dec_n.sv
// Combinational ADDR_W-to-N one-hot decoder with enable.
module addr_dec_n #(
  parameter int ADDR_W = 3,
  parameter int N      = 2**ADDR_W
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              en,
  output logic [N-1:0]      onehot
);

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign onehot[i] = en && (addr == ADDR_W'(i));
  end

endmodule

// File: rtl/addr_latch8_sync.sv
// Clocked 1-to-N addressable latch (74LS259 mode set) with an auto-increment
// pointer and a frame-done pulse after each full N-bit sweep.
module addr_latch8_sync
  import ttl_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int N      = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d,
  input  logic [ADDR_W-1:0] sel,
  input  logic              g,
  input  logic              clr,
  input  logic              inc,
  output logic [N-1:0]      q,
  output logic              y,
  output logic [ADDR_W-1:0] ptr,
  output logic              done
);

  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(N - 1);

  logic [ADDR_W-1:0] addr;
  logic [N-1:0]      hit;
  mode_t             mode;
  logic              adv;

  assign addr = inc ? ptr : sel;
  assign mode = {g, clr};
  assign adv  = !g && inc;
  assign y    = q[addr];

  addr_dec_n #(.ADDR_W(ADDR_W), .N(N)) u_dec (
    .addr   (addr),
    .en     (1'b1),
    .onehot (hit)
  );

  // Per-bit update keeps an X on d confined to the addressed bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        unique case (mode)
          MODE_LATCH: if (hit[i]) q[i] <= d;
          MODE_DEMUX: q[i] <= hit[i] ? d : 1'b0;
          MODE_CLR:   q[i] <= 1'b0;
          default:    q[i] <= q[i];
        endcase
      end
    end
  end

  // Clear-mode zeroing of the pointer is not a sweep completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr  <= '0;
      done <= 1'b0;
    end else begin
      done <= adv && (ptr == PTR_LAST);
      if (mode == MODE_CLR) ptr <= '0;
      else if (adv)         ptr <= ptr + 1'b1;
    end
  end

endmodule
